// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single unified memory port of the multi-cycle
// RV32 core between instruction fetch (IorD = 0) and load/store (IorD = 1).
// One transaction at a time: IDLE (grant) -> ISSUE (command) -> WAIT (response
// or timeout). Grants are combinational in IDLE only; responses are registered
// one-cycle rvalid pulses steered to the owning requester.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   if_req/if_addr -> if_gnt        fetch request, accepted in IDLE
//   d_req/d_we/d_addr/d_wdata/d_be  data request -> d_gnt
//   if_rvalid, d_rvalid, rdata, err response pulses, shared data, timeout flag
//   mem_req/we/addr/wdata/be        latched command toward memory
//   mem_ready, mem_rvalid, mem_rdata memory handshake and read data
//   owner, busy                     current owner (0 fetch, 1 data), not IDLE
//
// Build option: ARB_ROUND_ROBIN_EN selects alternating priority on ties;
// without it, data always wins over fetch.

module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic [3:0]        d_be,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic              err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [3:0]        mem_be,
   input  logic              mem_ready,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              owner,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   state_t            state_q;
   logic              owner_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic [3:0]        mem_be_q;
   logic [DATA_W-1:0] rdata_q;
   logic [7:0]        cnt_q;
   logic              if_rvalid_q;
   logic              d_rvalid_q;
   logic              err_q;
   logic              sel_data;

`ifdef ARB_ROUND_ROBIN_EN
   // Owner of the most recent grant; 0 after reset so data wins the first tie.
   logic              last_q;

   always_comb begin
      sel_data = d_req & (~if_req | ~last_q);
   end
`else
   always_comb begin
      sel_data = d_req;
   end
`endif

   always_comb begin
      d_gnt  = (state_q == IDLE) & sel_data;
      if_gnt = (state_q == IDLE) & if_req & ~sel_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         owner_q     <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= 4'b0000;
         rdata_q     <= '0;
         cnt_q       <= 8'd0;
         if_rvalid_q <= 1'b0;
         d_rvalid_q  <= 1'b0;
         err_q       <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         last_q      <= 1'b0;
`endif
      end else begin
         if_rvalid_q <= 1'b0;
         d_rvalid_q  <= 1'b0;
         err_q       <= 1'b0;
         case (state_q)
            IDLE: begin
               if (d_gnt || if_gnt) begin
                  owner_q <= d_gnt;
                  cnt_q   <= 8'd0;
                  state_q <= ISSUE;
`ifdef ARB_ROUND_ROBIN_EN
                  last_q  <= d_gnt;
`endif
                  if (d_gnt) begin
                     mem_we_q    <= d_we;
                     mem_addr_q  <= d_addr;
                     mem_wdata_q <= d_wdata;
                     mem_be_q    <= d_be;
                  end else begin
                     mem_we_q    <= 1'b0;
                     mem_addr_q  <= if_addr;
                     mem_wdata_q <= '0;
                     mem_be_q    <= 4'b1111;
                  end
               end
            end
            ISSUE: begin
               if (mem_ready) begin
                  // Only data can own a write, so a write completion is d_rvalid.
                  if (mem_we_q) begin
                     d_rvalid_q <= 1'b1;
                     state_q    <= IDLE;
                  end else begin
                     state_q    <= WAIT;
                  end
               end
            end
            WAIT: begin
               // A response arriving in the timeout cycle still wins.
               if (mem_rvalid) begin
                  rdata_q     <= mem_rdata;
                  if_rvalid_q <= ~owner_q;
                  d_rvalid_q  <= owner_q;
                  cnt_q       <= 8'd0;
                  state_q     <= IDLE;
               end else if (cnt_q == TIMEOUT_C) begin
                  rdata_q     <= '0;
                  if_rvalid_q <= ~owner_q;
                  d_rvalid_q  <= owner_q;
                  err_q       <= 1'b1;
                  cnt_q       <= 8'd0;
                  state_q     <= IDLE;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Decoded from the state register so reset drops mem_req immediately.
   assign mem_req   = (state_q == ISSUE);
   assign busy      = (state_q != IDLE);
   assign owner     = owner_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_be    = mem_be_q;
   assign rdata     = rdata_q;
   assign if_rvalid = if_rvalid_q;
   assign d_rvalid  = d_rvalid_q;
   assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: per-cycle vector table for the
// basic fetch/store/load flows, then hand-written sequences for arbitration,
// timeout and reset in the middle of a transaction.

module tb_mem_port_arbiter;

   localparam int TIMEOUT = 15;

   logic        clk, reset;
   logic        if_req, if_gnt, if_rvalid;
   logic [31:0] if_addr;
   logic        d_req, d_we, d_gnt, d_rvalid;
   logic [31:0] d_addr, d_wdata;
   logic [3:0]  d_be;
   logic [31:0] rdata;
   logic        err;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ready, mem_rvalid;
   logic [31:0] mem_rdata;
   logic        owner, busy;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .rdata(rdata), .err(err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata), .owner(owner), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        if_req;
      logic [31:0] if_addr;
      logic        d_req;
      logic        d_we;
      logic [31:0] d_addr;
      logic [31:0] d_wdata;
      logic [3:0]  d_be;
      logic        mem_ready;
      logic        mem_rvalid;
      logic [31:0] mem_rdata;
      logic        x_if_gnt;
      logic        x_d_gnt;
      logic        x_if_rvalid;
      logic        x_d_rvalid;
      logic        x_err;
      logic        x_mem_req;
      logic        x_busy;
      logic        x_owner;
      logic [31:0] x_rdata;
      logic        chk_cmd;
      logic        x_mem_we;
      logic [31:0] x_mem_addr;
      logic [31:0] x_mem_wdata;
      logic [3:0]  x_mem_be;
   } vec_t;

   vec_t tbl[$];
   vec_t t;
   int   checks = 0;
   int   failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   function automatic vec_t cmd(input vec_t v, input logic we, input logic [31:0] a,
                                input logic [31:0] wd, input logic [3:0] be, input logic own);
      vec_t r = v;
      r.x_mem_req   = 1'b1;
      r.x_busy      = 1'b1;
      r.x_owner     = own;
      r.chk_cmd     = 1'b1;
      r.x_mem_we    = we;
      r.x_mem_addr  = a;
      r.x_mem_wdata = wd;
      r.x_mem_be    = be;
      return r;
   endfunction

   task automatic clear_inputs();
      if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
      mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
   endtask

   task automatic wait_idle(input string nm);
      logic done = 1'b0;
      for (int k = 0; k < 60 && !done; k++) begin
         @(negedge clk);
         if (!busy) done = 1'b1;
      end
      chk({nm, " idle within bound"}, 32'(done), 32'd1);
   endtask

   initial begin
      logic got[4];
      logic exp_pat[4];
      int   ng, n, hit;

      clear_inputs();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst busy", 32'(busy), 0);
      chk("rst mem_req", 32'(mem_req), 0);
      chk("rst rdata", rdata, 0);
      chk("rst owner", 32'(owner), 0);
      chk("rst rvalid", 32'({if_rvalid, d_rvalid, err}), 0);
      chk("rst cmd", mem_addr | mem_wdata | 32'({mem_we, mem_be}), 0);
      reset = 1'b0;

      // ---- vector table: one row per clock cycle ----
      // single fetch 0x100
      t = '0; t.if_req = 1; t.if_addr = 32'h100; t.x_if_gnt = 1; tbl.push_back(t);
      t = '0; t.mem_ready = 1; t = cmd(t, 0, 32'h100, 0, 4'hF, 0); tbl.push_back(t);
      t = '0; t.mem_rvalid = 1; t.mem_rdata = 32'h00500093; t.x_busy = 1; tbl.push_back(t);
      t = '0; t.x_if_rvalid = 1; t.x_rdata = 32'h00500093; tbl.push_back(t);
      t = '0; t.x_rdata = 32'h00500093; tbl.push_back(t);
      // store 0x200 with mem_ready held off for 3 cycles
      t = '0; t.d_req = 1; t.d_we = 1; t.d_addr = 32'h200; t.d_wdata = 32'hDEADBEEF;
      t.d_be = 4'b0011; t.x_d_gnt = 1; t.x_rdata = 32'h00500093; tbl.push_back(t);
      for (int k = 0; k < 4; k++) begin
         t = '0; t.mem_ready = (k == 3); t.x_rdata = 32'h00500093;
         t = cmd(t, 1, 32'h200, 32'hDEADBEEF, 4'b0011, 1); tbl.push_back(t);
      end
      t = '0; t.x_d_rvalid = 1; t.x_rdata = 32'h00500093; tbl.push_back(t);
      t = '0; t.x_rdata = 32'h00500093; tbl.push_back(t);
      // data load 0x300, then fetch granted in the d_rvalid cycle
      t = '0; t.d_req = 1; t.d_addr = 32'h300; t.d_be = 4'hF; t.x_d_gnt = 1;
      t.x_rdata = 32'h00500093; tbl.push_back(t);
      t = '0; t.mem_ready = 1; t.x_rdata = 32'h00500093;
      t = cmd(t, 0, 32'h300, 0, 4'hF, 1); tbl.push_back(t);
      t = '0; t.x_busy = 1; t.x_owner = 1; t.x_rdata = 32'h00500093; tbl.push_back(t);
      t = '0; t.mem_rvalid = 1; t.mem_rdata = 32'hCAFEF00D; t.x_busy = 1; t.x_owner = 1;
      t.x_rdata = 32'h00500093; tbl.push_back(t);
      t = '0; t.if_req = 1; t.if_addr = 32'h104; t.x_d_rvalid = 1; t.x_if_gnt = 1;
      t.x_rdata = 32'hCAFEF00D; tbl.push_back(t);
      // mem_rvalid during ISSUE must be ignored
      t = '0; t.mem_ready = 1; t.mem_rvalid = 1; t.mem_rdata = 32'hBAD0BAD0;
      t.x_rdata = 32'hCAFEF00D; t = cmd(t, 0, 32'h104, 0, 4'hF, 0); tbl.push_back(t);
      t = '0; t.mem_rvalid = 1; t.mem_rdata = 32'h11112222; t.x_busy = 1;
      t.x_rdata = 32'hCAFEF00D; tbl.push_back(t);
      t = '0; t.x_if_rvalid = 1; t.x_rdata = 32'h11112222; tbl.push_back(t);
      // mem_rvalid in IDLE must be ignored
      t = '0; t.mem_rvalid = 1; t.mem_rdata = 32'h55555555; t.x_rdata = 32'h11112222; tbl.push_back(t);
      t = '0; t.x_rdata = 32'h11112222; tbl.push_back(t);

      for (int i = 0; i < tbl.size(); i++) begin
         @(posedge clk); #1;
         if_req = tbl[i].if_req; if_addr = tbl[i].if_addr;
         d_req = tbl[i].d_req; d_we = tbl[i].d_we; d_addr = tbl[i].d_addr;
         d_wdata = tbl[i].d_wdata; d_be = tbl[i].d_be;
         mem_ready = tbl[i].mem_ready; mem_rvalid = tbl[i].mem_rvalid;
         mem_rdata = tbl[i].mem_rdata;
         @(negedge clk);
         chk($sformatf("r%0d if_gnt", i), 32'(if_gnt), 32'(tbl[i].x_if_gnt));
         chk($sformatf("r%0d d_gnt", i), 32'(d_gnt), 32'(tbl[i].x_d_gnt));
         chk($sformatf("r%0d if_rvalid", i), 32'(if_rvalid), 32'(tbl[i].x_if_rvalid));
         chk($sformatf("r%0d d_rvalid", i), 32'(d_rvalid), 32'(tbl[i].x_d_rvalid));
         chk($sformatf("r%0d err", i), 32'(err), 32'(tbl[i].x_err));
         chk($sformatf("r%0d mem_req", i), 32'(mem_req), 32'(tbl[i].x_mem_req));
         chk($sformatf("r%0d busy", i), 32'(busy), 32'(tbl[i].x_busy));
         chk($sformatf("r%0d rdata", i), rdata, tbl[i].x_rdata);
         if (tbl[i].x_busy)
            chk($sformatf("r%0d owner", i), 32'(owner), 32'(tbl[i].x_owner));
         if (tbl[i].chk_cmd) begin
            chk($sformatf("r%0d mem_we", i), 32'(mem_we), 32'(tbl[i].x_mem_we));
            chk($sformatf("r%0d mem_addr", i), mem_addr, tbl[i].x_mem_addr);
            chk($sformatf("r%0d mem_wdata", i), mem_wdata, tbl[i].x_mem_wdata);
            chk($sformatf("r%0d mem_be", i), 32'(mem_be), 32'(tbl[i].x_mem_be));
         end
      end

      // ---- arbitration: both requesters held for 4 transactions ----
      @(posedge clk); #1;
      clear_inputs();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      exp_pat = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
      exp_pat = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
      if_req = 1; if_addr = 32'h800; d_req = 1; d_we = 1; d_addr = 32'h900;
      d_wdata = 32'h1; d_be = 4'hF; mem_ready = 1; mem_rvalid = 1; mem_rdata = 32'hA5A5A5A5;
      ng = 0;
      got = '{1'b0, 1'b0, 1'b0, 1'b0};
      for (int c = 0; c < 60 && ng < 4; c++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk("arb gnt exclusive", 32'(if_gnt & d_gnt), 0);
         if (d_gnt || if_gnt) begin
            got[ng] = d_gnt;
            ng++;
         end
      end
      chk("arb grant count", ng, 4);
      for (int k = 0; k < 4; k++)
         chk($sformatf("arb grant %0d is data", k), 32'(got[k]), 32'(exp_pat[k]));
      @(posedge clk); #1;
      if_req = 0; d_req = 0;
      wait_idle("arb");
      @(posedge clk); #1;
      mem_rvalid = 0;

      // ---- timeout: fetch read, no response ----
      if_req = 1; if_addr = 32'h400; mem_ready = 1;
      @(negedge clk);
      chk("to if_gnt", 32'(if_gnt), 1);
      n = 0; hit = 0;
      for (int c = 0; c < 40 && hit == 0; c++) begin
         @(posedge clk); #1;
         if_req = 0;
         @(negedge clk);
         n++;
         if (if_rvalid) hit = n;
         else chk($sformatf("to no early err c%0d", n), 32'(err | d_rvalid), 0);
      end
      chk("to rvalid cycle", hit, 2 + TIMEOUT + 1);
      chk("to err", 32'(err), 1);
      chk("to rdata", rdata, 0);
      chk("to busy", 32'(busy), 0);
      @(posedge clk); #1;
      d_req = 1; d_we = 1; d_addr = 32'h404; d_be = 4'hF;
      @(negedge clk);
      chk("to err one cycle", 32'(err | if_rvalid), 0);
      chk("to next d_gnt", 32'(d_gnt), 1);
      @(posedge clk); #1;
      d_req = 0;
      wait_idle("to store");

      // ---- reset in ISSUE drops mem_req asynchronously ----
      @(posedge clk); #1;
      clear_inputs();
      if_req = 1; if_addr = 32'h500;
      @(posedge clk); #1;
      if_req = 0;
      @(negedge clk);
      chk("rstI mem_req before", 32'(mem_req), 1);
      #2 reset = 1'b1;
      #1;
      chk("rstI mem_req async", 32'(mem_req), 0);
      chk("rstI busy async", 32'(busy), 0);
      @(negedge clk);
      reset = 1'b0;

      // ---- reset in WAIT, then stale mem_rvalid ----
      @(posedge clk); #1;
      if_req = 1; if_addr = 32'h600; mem_ready = 1; mem_rdata = 32'hFFFF0000;
      @(posedge clk); #1;
      if_req = 0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rstW busy in wait", 32'(busy), 1);
      chk("rstW mem_req in wait", 32'(mem_req), 0);
      #2 reset = 1'b1;
      #1;
      chk("rstW busy", 32'(busy), 0);
      chk("rstW owner", 32'(owner), 0);
      chk("rstW rdata", rdata, 0);
      chk("rstW pulses", 32'({if_rvalid, d_rvalid, err, mem_req}), 0);
      chk("rstW cmd", mem_addr | mem_wdata | 32'({mem_we, mem_be}), 0);
      @(negedge clk);
      reset = 1'b0;
      mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h00000077;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk($sformatf("rstW stale c%0d", c), 32'({if_rvalid, d_rvalid, err, busy}), 0);
         chk($sformatf("rstW stale rdata c%0d", c), rdata, 0);
      end
      @(posedge clk); #1;
      mem_rvalid = 0;
      if_req = 1; if_addr = 32'h700; mem_ready = 1; mem_rdata = 32'h00000013;
      @(negedge clk);
      chk("post if_gnt", 32'(if_gnt), 1);
      @(posedge clk); #1;
      if_req = 0;
      @(negedge clk);
      chk("post mem_addr", mem_addr, 32'h700);
      mem_rvalid = 1;
      hit = 0;
      for (int c = 0; c < 10 && hit == 0; c++) begin
         @(posedge clk); #1;
         @(negedge clk);
         if (if_rvalid) hit = 1;
      end
      chk("post if_rvalid", hit, 1);
      chk("post rdata", rdata, 32'h00000013);
      chk("post err", 32'(err), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
